// File: rtl/min_sec_counter_if.sv
// min_sec_counter_if: control pulses in, BCD time digits, hour carry and set-mode out
interface min_sec_counter_if;
   logic       tick;
   logic       mode_p;
   logic       inc_p;
   logic [3:0] SecH;
   logic [3:0] SecL;
   logic [3:0] MinH;
   logic [3:0] MinL;
   logic       hour_en;
   logic [1:0] set_mode;
   modport master (output tick, mode_p, inc_p,
                   input SecH, SecL, MinH, MinL, hour_en, set_mode);
   modport slave  (input tick, mode_p, inc_p,
                   output SecH, SecL, MinH, MinL, hour_en, set_mode);
endinterface

// File: rtl/min_sec_counter.sv
// min_sec_counter: cascaded BCD mod-60 seconds/minutes with time-set FSM and hour carry
module min_sec_counter #(
   parameter bit CLR_SEC_ON_SET = 1'b1,
   parameter bit HALT_IN_SET    = 1'b1
) (
   input logic              CP,
   input logic              nCR,
   min_sec_counter_if.slave bus
);
   typedef enum logic [1:0] {RUN = 2'b00, SET_HR = 2'b01, SET_MIN = 2'b10, SET_SEC = 2'b11} state_t;
   state_t     state, state_nx;
   logic [7:0] sec, min, sec_nx, min_nx;
   logic       inc, sec_max, min_max, sec_en, min_en, sec_clr;

   // BCD mod-60 increment; an out-of-range digit recovers the pair to 00
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      bcd_inc = (v[7:4] > 4'd5 || v[3:0] > 4'd9 || v == 8'h59) ? 8'h00 :
                (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'h0} : v + 8'h01;
   endfunction

   // mode state and time registers
   always_ff @(posedge CP or negedge nCR) begin
      if (!nCR) begin
         state <= RUN;
         sec   <= 8'h00;
         min   <= 8'h00;
      end else begin
         state <= state_nx;
         sec   <= sec_nx;
         min   <= min_nx;
      end
   end

   // next mode, counter enables and the same-edge hour carry; a mode press masks inc_p
   always_comb begin
      inc         = bus.inc_p & ~bus.mode_p;
      sec_max     = sec == 8'h59;
      min_max     = min == 8'h59;
      state_nx    = bus.mode_p ? state_t'(state + 2'd1) : state;
      sec_clr     = CLR_SEC_ON_SET && state == SET_SEC && inc;
      sec_en      = (bus.tick && (state == RUN || !HALT_IN_SET)) || (state == SET_SEC && inc);
      min_en      = (state == RUN && bus.tick && sec_max) || (state == SET_MIN && inc);
      sec_nx      = sec_clr ? 8'h00 : sec_en ? bcd_inc(sec) : sec;
      min_nx      = min_en ? bcd_inc(min) : min;
      bus.hour_en = (state == RUN && bus.tick && min_max && sec_max) || (state == SET_HR && inc);
   end

   assign {bus.SecH, bus.SecL} = sec;
   assign {bus.MinH, bus.MinL} = min;
   assign bus.set_mode         = state;
endmodule

// File: tb/tb_min_sec_counter.sv
// tb_min_sec_counter: directed vectors with hand-computed times for min_sec_counter
module tb_min_sec_counter;
   logic CP = 1'b0;
   logic nCR = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   he_cnt = 0;
   int   he0;
   logic he;

   min_sec_counter_if bus ();
   min_sec_counter dut (.CP(CP), .nCR(nCR), .bus(bus));

   always #5 CP = ~CP;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] mmss();
      return {bus.MinH, bus.MinL, bus.SecH, bus.SecL};
   endfunction

   // one CP cycle from a negedge: drive, sample hour_en before the edge, clear at next negedge
   task automatic step(input logic t, input logic m, input logic i);
      bus.tick = t;
      bus.mode_p = m;
      bus.inc_p = i;
      #1;
      he = bus.hour_en;
      if (he) he_cnt++;
      @(negedge CP);
      bus.tick = 1'b0;
      bus.mode_p = 1'b0;
      bus.inc_p = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0);
   endtask

   task automatic modes(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0);
   endtask

   task automatic incs(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      bus.tick = 1'b0;
      bus.mode_p = 1'b0;
      bus.inc_p = 1'b0;
      @(negedge CP);
      check("rst_time", mmss(), 16'h0000);
      check("rst_mode", bus.set_mode, 2'b00);
      check("rst_hour_en", bus.hour_en, 1'b0);
      nCR = 1'b1;
      @(negedge CP);
      // 1: 60 ticks
      he0 = he_cnt;
      ticks(59);
      check("t1_59", mmss(), 16'h0059);
      ticks(1);
      check("t1_wrap", mmss(), 16'h0100);
      check("t1_no_hour", he_cnt - he0, 0);
      // 2: preload 59:58 then wrap
      modes(2);
      check("t2_setmin", bus.set_mode, 2'b10);
      incs(58);
      check("t2_min59", mmss(), 16'h5900);
      modes(2);
      check("t2_run", bus.set_mode, 2'b00);
      ticks(58);
      check("t2_5958", mmss(), 16'h5958);
      step(1'b1, 1'b0, 1'b0);
      check("t2_he_5959", he, 1'b0);
      check("t2_5959", mmss(), 16'h5959);
      step(1'b1, 1'b0, 1'b0);
      check("t2_he_wrap", he, 1'b1);
      check("t2_0000", mmss(), 16'h0000);
      // 3: SET_HR pulses hour_en only
      ticks(5);
      modes(1);
      check("t3_mode", bus.set_mode, 2'b01);
      he0 = he_cnt;
      incs(3);
      check("t3_pulses", he_cnt - he0, 3);
      step(1'b1, 1'b0, 1'b0);
      check("t3_frozen", mmss(), 16'h0005);
      // 4: SET_MIN wrap without carry, SET_SEC clear
      modes(1);
      incs(59);
      check("t4_min59", mmss(), 16'h5905);
      step(1'b0, 1'b0, 1'b1);
      check("t4_he", he, 1'b0);
      check("t4_min00", mmss(), 16'h0005);
      modes(2);
      ticks(32);
      check("t4_sec37", mmss(), 16'h0037);
      modes(3);
      check("t4_setsec", bus.set_mode, 2'b11);
      step(1'b0, 1'b0, 1'b1);
      check("t4_clr", mmss(), 16'h0000);
      // 5: mode wins over inc, mode with tick, full mode cycle
      modes(3);
      incs(3);
      check("t5_min03", mmss(), 16'h0300);
      step(1'b0, 1'b1, 1'b1);
      check("t5_mode_win", bus.set_mode, 2'b11);
      check("t5_min_keep", mmss(), 16'h0300);
      modes(1);
      step(1'b1, 1'b1, 1'b0);
      check("t5_tick_mode_t", mmss(), 16'h0301);
      check("t5_tick_mode_s", bus.set_mode, 2'b01);
      modes(3);
      modes(4);
      check("t5_cycle", bus.set_mode, 2'b00);
      // 6: illegal BCD recovery
      force dut.sec = 8'h0A;
      #1;
      release dut.sec;
      check("t6_forced", bus.SecL, 4'hA);
      @(negedge CP);
      step(1'b1, 1'b0, 1'b0);
      check("t6_sec0a", mmss(), 16'h0300);
      force dut.sec = 8'hF3;
      #1;
      release dut.sec;
      @(negedge CP);
      step(1'b1, 1'b0, 1'b0);
      check("t6_secf3", mmss(), 16'h0300);
      force dut.min = 8'h7A;
      force dut.sec = 8'h59;
      #1;
      release dut.min;
      release dut.sec;
      @(negedge CP);
      step(1'b1, 1'b0, 1'b0);
      check("t6_min_he", he, 1'b0);
      check("t6_min_rec", mmss(), 16'h0000);
      // 6: async reset mid-count from 42:17 in SET_MIN
      modes(2);
      incs(42);
      modes(2);
      ticks(17);
      check("t6_4217", mmss(), 16'h4217);
      modes(2);
      bus.tick = 1'b1;
      bus.inc_p = 1'b1;
      #2;
      nCR = 1'b0;
      #1;
      check("t6_async_t", mmss(), 16'h0000);
      check("t6_async_s", bus.set_mode, 2'b00);
      @(negedge CP);
      check("t6_held", mmss(), 16'h0000);
      bus.tick = 1'b0;
      bus.inc_p = 1'b0;
      nCR = 1'b1;
      @(negedge CP);
      step(1'b1, 1'b0, 1'b0);
      check("t6_resume", mmss(), 16'h0001);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
